zap_wb_arbiter_n: RTL and testbench
===================================

// Module: zap_wb_arbiter_n
// PURPOSE
//  N-master Wishbone B3 arbiter. Generalises the fixed two-master code/data merger to
//  NUM_MASTERS requestors (I-cache, D-cache, page-table walker, DMA, debug).
//  Selectable fixed-priority or round-robin arbitration. Grant is locked for the whole
//  CYC cycle, including registered bursts, then handed over. Drives the single bus into
//  zap_wb_adapter.
// PARAMETERS
//  NUM_MASTERS   4    number of requesting masters, 2..16
//  ARB_MODE      1    0 = fixed priority (index 0 highest), 1 = round-robin
//  ADDR_W        32   address width
//  DATA_W        32   data width, multiple of 8; SEL width = DATA_W/8
// PORTS
//  i_clk       in   1                 core clock, posedge
//  i_reset     in   1                 synchronous, active-high reset
//  i_m_cyc     in   N                 per-master CYC
//  i_m_stb     in   N                 per-master STB
//  i_m_we      in   N                 per-master WE
//  i_m_sel     in   N*DATA_W/8        per-master SEL, master k at [k*S +: S]
//  i_m_dat     in   N*DATA_W          per-master write data, packed as SEL
//  i_m_adr     in   N*ADDR_W          per-master address, packed as SEL
//  i_m_cti     in   N*3               per-master CTI
//  o_m_ack     out  N                 ACK, routed only to the granted master
//  o_m_err     out  N                 ERR, routed only to the granted master
//  o_m_dat     out  DATA_W            read data, broadcast to all masters
//  o_wb_cyc/stb/we  out  1            slave-side bus controls
//  o_wb_sel    out  DATA_W/8          slave-side byte select
//  o_wb_dat    out  DATA_W            slave-side write data
//  o_wb_adr    out  ADDR_W            slave-side address
//  o_wb_cti    out  3                 slave-side cycle type
//  i_wb_ack/err     in   1            slave response
//  i_wb_dat    in   DATA_W            slave read data
//  o_grant     out  $clog2(N)         index of current owner (debug/perf)
//  o_busy      out  1                 1 while a grant is held
// BEHAVIOUR
//  - Reset: state=IDLE, grant=0, rr_ptr=0; o_wb_cyc/stb/we=0; o_wb_sel/dat/adr=0;
//    o_wb_cti=3'b000; o_m_ack=o_m_err=0; o_busy=0.
//  - FSM IDLE -> GRANT -> (cyc of owner low) -> IDLE. IDLE lasts at least 1 cycle, so
//    there is always one dead cycle between owners.
//  - IDLE: if any i_m_cyc is high, latch winner into grant and go to GRANT next edge.
//    Request-to-o_wb_cyc latency is 1 cycle.
//  - Fixed mode: lowest index with cyc=1 wins.
//  - RR mode: first index with cyc=1 searching rr_ptr, rr_ptr+1, ... mod N. On grant,
//    rr_ptr <= winner+1 mod N (wraps N-1 -> 0).
//  - GRANT: all o_wb_* come combinationally from the owner's inputs. Ack/err path is
//    combinational: o_m_ack[grant] = i_wb_ack & owner cyc & owner stb. Non-owners see 0.
//  - Release when the owner's cyc=0 (sampled at posedge). Bursts (CTI 010) and
//    incrementing bursts stay locked until cyc drops, regardless of CTI=111.
//  - In IDLE, or after release, o_wb_cyc=o_wb_stb=0. Stray i_wb_ack/err are dropped,
//    not routed.
//  - Requests arriving during GRANT are not lost. They are held by the master's own cyc
//    and arbitrated in the next IDLE.
//  - Owner cyc high with stb low is a wait state: grant is held, no timeout.
//  - Simultaneous release by the owner and a request from the same master: it is
//    re-arbitrated fairly in IDLE. In RR mode it loses to any other requester.
//  - Reset mid-cycle: FSM returns to IDLE immediately, outputs take reset values the
//    next cycle, and the bus cycle is abandoned.
// STRUCTURE
//  - Shared: CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111 go into
//    zap_localparams.vh. Fixed/RR mode constants go there too.
//  - Sub-module zap_rr_arbiter #(N): inputs req[N], ptr, mode; outputs one-hot gnt and
//    binary index. Purely combinational priority rotate.
//  - Top level holds the FSM, grant/rr_ptr registers and the output muxes.
// TESTING
//  - Reset: hold i_reset 3 cycles with all cyc=1 -> o_wb_cyc=0, o_busy=0, o_grant=0
//    throughout.
//  - Single master: m2 single read at adr 0x1000, slave acks with 0xDEADBEEF after
//    2 cycles -> o_wb_cyc rises 1 cycle after the request; o_m_ack=4'b0100 for exactly
//    1 cycle; o_m_dat=0xDEADBEEF.
//  - Fixed mode, N=4: m1 and m3 request together -> m1 served first, 1 idle cycle, then
//    m3. o_grant sequence 1, 3.
//  - RR mode: all 4 masters request continuously, each doing single transfers -> grant
//    order 0,1,2,3,0. No master waits more than 3 cycles of other owners.
//  - Burst lock: m0 runs a 4-beat CTI=010 burst ending in 111 while m1 requests -> m1
//    is not granted until m0 drops cyc. o_m_ack[1]=0 during all 4 beats.
//  - Reset mid-burst: assert i_reset on beat 2 of m0's burst -> next cycle
//    o_wb_cyc=0 and grant=0. After reset, a pending m3 request is granted normally.

Source files
------------

// File: rtl/zap_wb_arbiter_n_pkg.sv
// zap_wb_arbiter_n_pkg: shared Wishbone cycle-type codes, arbitration modes and FSM states
// for the N-master arbiter.
package zap_wb_arbiter_n_pkg;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction
endpackage

// File: rtl/zap_wb_arbiter_n_rr.sv
// zap_rr_arbiter: combinational priority search starting at ptr (round-robin) or at 0 (fixed).
module zap_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          mode,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    int s;
    logic [IW-1:0] k;
    // Scan from the farthest offset down so the nearest requester overwrites last.
    always_comb begin
        gnt = '0;
        idx = '0;
        s = 0;
        k = '0;
        for (int i = N - 1; i >= 0; i--) begin
            s = (mode ? int'(ptr) : 0) + i;
            s = (s >= N) ? s - N : s;
            k = IW'(s);
            if (req[k]) begin
                gnt = '0;
                gnt[k] = 1'b1;
                idx = k;
            end
        end
    end
endmodule

// File: rtl/zap_wb_arbiter_n.sv
// zap_wb_arbiter_n: N-master Wishbone B3 arbiter; grant is locked for a whole CYC and
// followed by at least one idle cycle before the next owner.
module zap_wb_arbiter_n
    import zap_wb_arbiter_n_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ARB_MODE    = 1,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic [NUM_MASTERS-1:0]           i_m_cyc,
    input  logic [NUM_MASTERS-1:0]           i_m_stb,
    input  logic [NUM_MASTERS-1:0]           i_m_we,
    input  logic [NUM_MASTERS*DATA_W/8-1:0]  i_m_sel,
    input  logic [NUM_MASTERS*DATA_W-1:0]    i_m_dat,
    input  logic [NUM_MASTERS*ADDR_W-1:0]    i_m_adr,
    input  logic [NUM_MASTERS*3-1:0]         i_m_cti,
    output logic [NUM_MASTERS-1:0]           o_m_ack,
    output logic [NUM_MASTERS-1:0]           o_m_err,
    output logic [DATA_W-1:0]                o_m_dat,
    output logic                             o_wb_cyc,
    output logic                             o_wb_stb,
    output logic                             o_wb_we,
    output logic [DATA_W/8-1:0]              o_wb_sel,
    output logic [DATA_W-1:0]                o_wb_dat,
    output logic [ADDR_W-1:0]                o_wb_adr,
    output logic [2:0]                       o_wb_cti,
    input  logic                             i_wb_ack,
    input  logic                             i_wb_err,
    input  logic [DATA_W-1:0]                i_wb_dat,
    output logic [$clog2(NUM_MASTERS)-1:0]   o_grant,
    output logic                             o_busy
);
    localparam int S  = DATA_W / 8;
    localparam int GW = $clog2(NUM_MASTERS);

    logic [0:0]             state_q, state_d;
    logic [GW-1:0]          grant_q, grant_d, rr_ptr_q, rr_ptr_d, win_idx;
    logic [NUM_MASTERS-1:0] win_gnt;
    logic                   busy, own_cyc, own_stb;

    zap_rr_arbiter #(.N(NUM_MASTERS)) u_arb (
        .req  (i_m_cyc),
        .ptr  (rr_ptr_q),
        .mode (ARB_MODE == ARB_RR),
        .gnt  (win_gnt),
        .idx  (win_idx)
    );

    assign busy    = state_q == ST_GRANT;
    assign own_cyc = i_m_cyc[grant_q];
    assign own_stb = own_cyc & i_m_stb[grant_q];

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        if (state_q == ST_IDLE) begin
            if (|win_gnt) begin
                state_d  = ST_GRANT;
                grant_d  = win_idx;
                rr_ptr_d = (ARB_MODE == ARB_RR) ? GW'(wrap_inc(int'(win_idx), NUM_MASTERS)) : rr_ptr_q;
            end
        end else if (!own_cyc) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Bus and response paths are combinational from the owner; nothing leaks while idle.
    always_comb begin
        o_wb_cyc = busy & own_cyc;
        o_wb_stb = busy & own_stb;
        o_wb_we  = busy & i_m_we[grant_q];
        o_wb_sel = busy ? i_m_sel[grant_q*S +: S] : '0;
        o_wb_dat = busy ? i_m_dat[grant_q*DATA_W +: DATA_W] : '0;
        o_wb_adr = busy ? i_m_adr[grant_q*ADDR_W +: ADDR_W] : '0;
        o_wb_cti = busy ? i_m_cti[grant_q*3 +: 3] : CTI_CLASSIC;
        o_m_ack = '0;
        o_m_err = '0;
        o_m_ack[grant_q] = o_wb_stb & i_wb_ack;
        o_m_err[grant_q] = o_wb_stb & i_wb_err;
        o_m_dat = i_wb_dat;
        o_grant = grant_q;
        o_busy  = busy;
    end
endmodule

// File: tb/tb_zap_wb_arbiter_n.sv
// tb_zap_wb_arbiter_n: drives a round-robin and a fixed-priority arbiter with shared stimulus
// and compares both against a per-cycle ownership model plus directed expectations.
module tb_zap_wb_arbiter_n;
    import zap_wb_arbiter_n_pkg::*;

    typedef struct packed {
        logic        busy;
        logic [1:0]  grant;
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] adr;
        logic [2:0]  cti;
        logic [3:0]  ack;
        logic [3:0]  err;
        logic [31:0] mdat;
    } outs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [3:0]   m_cyc, m_stb, m_we;
    logic [15:0]  m_sel;
    logic [127:0] m_dat, m_adr;
    logic [11:0]  m_cti;
    logic         wb_ack, wb_err;
    logic [31:0]  wb_dat;

    logic [3:0]  rr_ack, rr_err, fx_ack, fx_err;
    logic [31:0] rr_mdat, rr_dat, rr_adr, fx_mdat, fx_dat, fx_adr;
    logic        rr_cyc, rr_stb, rr_we, rr_busy, fx_cyc, fx_stb, fx_we, fx_busy;
    logic [3:0]  rr_sel, fx_sel;
    logic [2:0]  rr_cti, fx_cti;
    logic [1:0]  rr_grant, fx_grant;
    outs_t       obs_rr, obs_fx;

    zap_wb_arbiter_n #(.NUM_MASTERS(4), .ARB_MODE(1), .ADDR_W(32), .DATA_W(32)) u_rr (
        .i_clk(clk), .i_reset(rst), .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we),
        .i_m_sel(m_sel), .i_m_dat(m_dat), .i_m_adr(m_adr), .i_m_cti(m_cti),
        .o_m_ack(rr_ack), .o_m_err(rr_err), .o_m_dat(rr_mdat),
        .o_wb_cyc(rr_cyc), .o_wb_stb(rr_stb), .o_wb_we(rr_we), .o_wb_sel(rr_sel),
        .o_wb_dat(rr_dat), .o_wb_adr(rr_adr), .o_wb_cti(rr_cti),
        .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_dat(wb_dat),
        .o_grant(rr_grant), .o_busy(rr_busy)
    );

    zap_wb_arbiter_n #(.NUM_MASTERS(4), .ARB_MODE(0), .ADDR_W(32), .DATA_W(32)) u_fx (
        .i_clk(clk), .i_reset(rst), .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we),
        .i_m_sel(m_sel), .i_m_dat(m_dat), .i_m_adr(m_adr), .i_m_cti(m_cti),
        .o_m_ack(fx_ack), .o_m_err(fx_err), .o_m_dat(fx_mdat),
        .o_wb_cyc(fx_cyc), .o_wb_stb(fx_stb), .o_wb_we(fx_we), .o_wb_sel(fx_sel),
        .o_wb_dat(fx_dat), .o_wb_adr(fx_adr), .o_wb_cti(fx_cti),
        .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_dat(wb_dat),
        .o_grant(fx_grant), .o_busy(fx_busy)
    );

    assign obs_rr = {rr_busy, rr_grant, rr_cyc, rr_stb, rr_we, rr_sel, rr_dat, rr_adr, rr_cti, rr_ack, rr_err, rr_mdat};
    assign obs_fx = {fx_busy, fx_grant, fx_cyc, fx_stb, fx_we, fx_sel, fx_dat, fx_adr, fx_cti, fx_ack, fx_err, fx_mdat};

    int checks = 0;
    int errors = 0;
    // Model index 0 is the round-robin instance, 1 the fixed-priority one.
    logic       busy_m[2];
    logic [1:0] own_m[2];
    logic [1:0] ptr_m[2];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic outs_t expect_out(input int d);
        outs_t e;
        logic [1:0] o;
        e = '0;
        o = own_m[d];
        e.busy  = busy_m[d];
        e.grant = o;
        e.mdat  = wb_dat;
        if (busy_m[d]) begin
            e.cyc = m_cyc[o];
            e.stb = m_cyc[o] & m_stb[o];
            e.we  = m_we[o];
            e.sel = m_sel[o*4 +: 4];
            e.dat = m_dat[o*32 +: 32];
            e.adr = m_adr[o*32 +: 32];
            e.cti = m_cti[o*3 +: 3];
            e.ack[o] = e.stb & wb_ack;
            e.err[o] = e.stb & wb_err;
        end
        return e;
    endfunction

    task automatic model_edge();
        logic [1:0] k;
        bit found;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                busy_m[d] = 1'b0;
                own_m[d]  = 2'd0;
                ptr_m[d]  = 2'd0;
            end else if (!busy_m[d]) begin
                if (|m_cyc) begin
                    found = 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        k = (d == 0 ? ptr_m[d] : 2'd0) + 2'(i);
                        if (m_cyc[k] && !found) begin
                            own_m[d] = k;
                            found = 1'b1;
                        end
                    end
                    busy_m[d] = 1'b1;
                    if (d == 0) ptr_m[d] = own_m[d] + 2'd1;
                end
            end else if (!m_cyc[own_m[d]]) begin
                busy_m[d] = 1'b0;
            end
        end
    endtask

    task automatic settle();
        #1;
        chk("rr_model", obs_rr, expect_out(0));
        chk("fx_model", obs_fx, expect_out(1));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0;
        m_dat = '0; m_adr = '0; m_cti = '0;
        wb_ack = 1'b0; wb_err = 1'b0; wb_dat = '0;
    endtask

    task automatic req(input int m, input logic [31:0] adr, input logic [2:0] cti);
        m_cyc[m] = 1'b1;
        m_stb[m] = 1'b1;
        m_adr[m*32 +: 32] = adr;
        m_cti[m*3 +: 3] = cti;
        m_sel[m*4 +: 4] = 4'hF;
    endtask

    task automatic drop(input int m);
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
    endtask

    int order[5] = '{0, 1, 2, 3, 0};

    initial begin
        for (int d = 0; d < 2; d++) begin
            busy_m[d] = 1'b0; own_m[d] = 2'd0; ptr_m[d] = 2'd0;
        end
        idle_inputs();
        rst = 1'b1;
        m_cyc = 4'hF;
        m_stb = 4'hF;
        tick();
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("rst_cyc", {rr_cyc, fx_cyc}, 2'b00);
            chk("rst_busy", {rr_busy, fx_busy}, 2'b00);
            chk("rst_grant", {rr_grant, fx_grant}, 4'h0);
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        settle();
        tick();

        // single read by master 2
        req(2, 32'h1000, CTI_CLASSIC);
        settle();
        chk("m2_latency", {rr_cyc, fx_cyc}, 2'b00);
        tick();
        settle();
        chk("m2_cyc", {rr_cyc, fx_cyc}, 2'b11);
        chk("m2_adr", rr_adr, 32'h1000);
        chk("m2_grant", {rr_grant, fx_grant}, 4'b1010);
        chk("m2_wait", {rr_ack, fx_ack}, 8'h00);
        tick();
        wb_ack = 1'b1;
        wb_dat = 32'hDEADBEEF;
        settle();
        chk("m2_ack", {rr_ack, fx_ack}, 8'b0100_0100);
        chk("m2_dat", rr_mdat, 32'hDEADBEEF);
        tick();
        drop(2);
        wb_ack = 1'b0;
        wb_dat = '0;
        settle();
        chk("m2_ack_once", rr_ack | fx_ack, 4'h0);
        tick();
        settle();
        chk("m2_idle", {rr_busy, fx_busy}, 2'b00);
        tick();

        // masters 1 and 3 together: 1 first, dead cycle, then 3
        do_reset();
        req(1, 32'h2000, CTI_CLASSIC);
        req(3, 32'h3000, CTI_CLASSIC);
        settle();
        tick();
        wb_ack = 1'b1;
        settle();
        chk("fx_first", fx_grant, 2'd1);
        chk("fx_first_ack", fx_ack, 4'b0010);
        tick();
        drop(1);
        wb_ack = 1'b0;
        settle();
        tick();
        settle();
        chk("fx_dead", {fx_busy, fx_cyc}, 2'b00);
        tick();
        wb_ack = 1'b1;
        settle();
        chk("fx_second", fx_grant, 2'd3);
        chk("fx_second_ack", fx_ack, 4'b1000);
        chk("fx_second_adr", fx_adr, 32'h3000);
        tick();
        drop(3);
        wb_ack = 1'b0;
        settle();
        tick();

        // all four request continuously, one beat each
        do_reset();
        for (int m = 0; m < 4; m++) req(m, 32'h4000 + m * 16, CTI_CLASSIC);
        for (int j = 0; j < 5; j++) begin
            settle();
            chk("rr_gap", rr_busy, 1'b0);
            tick();
            wb_ack = 1'b1;
            settle();
            chk("rr_order", rr_grant, order[j]);
            chk("rr_ack", rr_ack, 1 << order[j]);
            tick();
            wb_ack = 1'b0;
            drop(order[j]);
            settle();
            tick();
            req(order[j], 32'h4000 + order[j] * 16, CTI_CLASSIC);
        end

        // burst lock: m0 4-beat incrementing burst ending in EOB while m1 waits
        do_reset();
        req(0, 32'h5000, CTI_INCR);
        req(1, 32'h6000, CTI_CLASSIC);
        settle();
        tick();
        for (int b = 0; b < 4; b++) begin
            m_cti[2:0]  = (b == 3) ? CTI_EOB : CTI_INCR;
            m_adr[31:0] = 32'h5000 + b * 4;
            wb_ack = 1'b1;
            settle();
            chk("burst_grant", {rr_grant, fx_grant}, 4'h0);
            chk("burst_ack", {rr_ack, fx_ack}, 8'h11);
            tick();
        end
        m_stb[0] = 1'b0;
        wb_ack = 1'b0;
        settle();
        chk("burst_hold", {rr_busy, fx_busy, rr_grant, fx_grant}, 6'b110000);
        tick();
        drop(0);
        settle();
        tick();
        settle();
        chk("burst_dead", {rr_busy, fx_busy}, 2'b00);
        tick();
        settle();
        chk("burst_next", {rr_grant, fx_grant}, 4'b0101);
        tick();

        // reset on beat 2 of m0 burst with m3 pending
        do_reset();
        req(0, 32'h7000, CTI_INCR);
        req(3, 32'h8000, CTI_CLASSIC);
        settle();
        tick();
        wb_ack = 1'b1;
        settle();
        tick();
        rst = 1'b1;
        settle();
        tick();
        rst = 1'b0;
        wb_ack = 1'b0;
        drop(0);
        settle();
        chk("rst_mid_cyc", {rr_cyc, fx_cyc}, 2'b00);
        chk("rst_mid_grant", {rr_busy, fx_busy, rr_grant, fx_grant}, 6'b000000);
        tick();
        settle();
        chk("rst_mid_m3", {rr_busy, fx_busy, rr_grant, fx_grant}, 6'b111111);
        tick();
        drop(3);
        settle();
        tick();

        // random traffic, including stray acks and occasional resets
        for (int c = 0; c < 600; c++) begin
            for (int m = 0; m < 4; m++)
                if ($urandom_range(3) == 0) m_cyc[m] = ~m_cyc[m];
            m_stb  = 4'($urandom);
            m_we   = 4'($urandom);
            m_sel  = 16'($urandom);
            m_dat  = {$urandom, $urandom, $urandom, $urandom};
            m_adr  = {$urandom, $urandom, $urandom, $urandom};
            m_cti  = 12'($urandom);
            wb_ack = 1'($urandom);
            wb_err = ($urandom_range(7) == 0);
            wb_dat = $urandom;
            rst    = ($urandom_range(99) == 0);
            settle();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
